// File: rtl/ins_loader.sv
`default_nettype none
// ============================================================================
// Module      : ins_loader
// Description : Boot-time loader; assembles a checksummed host byte stream
//               into 32-bit words and writes them to instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module ins_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W+1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_run
);

    localparam logic [16:0] C_MAX_WORDS = 17'(MAX_WORDS);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CNT_HI = 4'd1,
        S_CNT_LO = 4'd2,
        S_DATA   = 4'd3,
        S_WRITE  = 4'd4,
        S_CSUM   = 4'd5,
        S_DONE   = 4'd6,
        S_ERR    = 4'd7
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_count;
    logic [7:0]          r_csum;
    logic [31:0]         r_word;
    logic [1:0]          r_byte_idx;
    // One bit wider than the address so the index can reach N without wrapping.
    logic [ADDR_W:0]     r_word_idx;
    logic [ADDR_W+1:0]   r_wr_addr;
    logic [31:0]         r_wr_data;

    logic                w_in_ready;
    logic                w_accept;
    logic [15:0]         w_cnt_new;
    logic [16:0]         w_idx_inc;
    logic                w_last_word;

    assign w_in_ready  = (r_state == S_CNT_HI) || (r_state == S_CNT_LO) ||
                         (r_state == S_DATA)   || (r_state == S_CSUM);
    assign w_accept    = w_in_ready && in_valid;
    assign w_cnt_new   = {r_count[15:8], in_data};
    assign w_idx_inc   = 17'(r_word_idx) + 17'd1;
    assign w_last_word = (w_idx_inc == {1'b0, r_count});

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_CNT_HI;
            S_CNT_HI: if (w_accept) w_next = S_CNT_LO;
            S_CNT_LO: begin
                if (w_accept) begin
                    if ({1'b0, w_cnt_new} > C_MAX_WORDS) w_next = S_ERR;
                    else if (w_cnt_new == 16'd0)         w_next = S_CSUM;
                    else                                 w_next = S_DATA;
                end
            end
            S_DATA:   if (w_accept && (r_byte_idx == 2'd3)) w_next = S_WRITE;
            S_WRITE:  w_next = w_last_word ? S_CSUM : S_DATA;
            S_CSUM: begin
                if (w_accept) w_next = (in_data == r_csum) ? S_DONE : S_ERR;
            end
            S_DONE:   if (start) w_next = S_CNT_HI;
            S_ERR:    if (start) w_next = S_CNT_HI;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_csum     <= '0;
            r_word     <= '0;
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_CNT_HI: if (w_accept) r_count[15:8] <= in_data;
                S_CNT_LO: begin
                    if (w_accept) begin
                        r_count[7:0] <= in_data;
                        r_csum       <= '0;
                        r_word       <= '0;
                        r_byte_idx   <= '0;
                        r_word_idx   <= '0;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_word     <= {r_word[23:0], in_data};
                        r_csum     <= r_csum ^ in_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        // Capture the write beat here so the bus holds between writes.
                        if (r_byte_idx == 2'd3) begin
                            r_wr_data <= {r_word[23:0], in_data};
                            r_wr_addr <= {r_word_idx[ADDR_W-1:0], 2'b00};
                        end
                    end
                end
                S_WRITE:  r_word_idx <= r_word_idx + 1'b1;
                default:  ;
            endcase
        end
    end

    assign in_ready = w_in_ready;
    assign wr_en    = (r_state == S_WRITE);
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign busy     = w_in_ready || (r_state == S_WRITE);
    assign done     = (r_state == S_DONE);
    assign error    = (r_state == S_ERR);
    assign cpu_run  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ins_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ins_loader
// Description : Self-checking bench for ins_loader using stream vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ins_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W+1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              error;
    logic              cpu_run;

    ins_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .error(error), .cpu_run(cpu_run)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [ADDR_W+1:0] wq_addr[$];
    logic [31:0]       wq_data[$];
    always @(negedge clk) begin
        if (wr_en) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Streams len bytes MSB-first from bs; gap idle cycles between bytes,
    // optionally pulsing start inside each gap.
    task automatic send(input logic [95:0] bs, input int len, input int gap,
                        input bit mid_start, output int first_acc);
        first_acc = 0;
        for (int i = 0; i < len; i++) begin
            int t;
            in_valid = 1'b1;
            in_data  = bs[95-8*i -: 8];
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 40) begin
                t++;
                @(negedge clk);
            end
            if (!in_ready) begin
                n_chk++;
                $display("FAIL accept_timeout: byte %0d in_ready=0 after 40 cycles, expected 1", i);
                in_valid = 1'b0;
                return;
            end
            tick();
            if (i == 0) first_acc = cyc;
            in_valid = 1'b0;
            if (i < len - 1) begin
                for (int g = 0; g < gap; g++) begin
                    if (mid_start && g == 1) start = 1'b1;
                    tick();
                    start = 1'b0;
                end
            end
        end
    endtask

    typedef struct {
        string       name;
        logic [95:0] bs;
        int          len;
        logic        exp_done;
        logic        exp_err;
        int          exp_nwr;
        logic [31:0] d0;
        logic [31:0] d1;
        int          exp_cyc;
    } vec_t;

    localparam logic [95:0] GOOD = {16'h0002, 32'h20080005, 32'h8C090004, 8'hAC, 8'h00};
    localparam logic [95:0] BAD  = {16'h0002, 32'h20080005, 32'h8C090004, 8'hAD, 8'h00};
    localparam logic [95:0] ONE  = {16'h0001, 32'h12345678, 8'h08, 40'h0};

    vec_t vt[5];

    initial begin
        int fa;
        int ncyc;

        vt[0] = '{"good",     GOOD,                 11, 1'b1, 1'b0, 2, 32'h20080005, 32'h8C090004, 13};
        vt[1] = '{"bad_csum", BAD,                  11, 1'b0, 1'b1, 2, 32'h20080005, 32'h8C090004, 13};
        vt[2] = '{"empty",    {24'h000000, 72'h0},   3, 1'b1, 1'b0, 0, 32'h0,        32'h0,         3};
        vt[3] = '{"oversize", {16'h0101, 80'h0},     2, 1'b0, 1'b1, 0, 32'h0,        32'h0,         2};
        vt[4] = '{"one_word", ONE,                   7, 1'b1, 1'b0, 1, 32'h12345678, 32'h0,         8};

        // Reset with start held high: start must not take effect.
        rst_n = 1'b0;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en",    wr_en,    0);
        chk("rst_wr_addr",  wr_addr,  0);
        chk("rst_wr_data",  wr_data,  0);
        chk("rst_busy",     busy,     0);
        chk("rst_done",     done,     0);
        chk("rst_error",    error,    0);
        chk("rst_cpu_run",  cpu_run,  0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("start_during_rst_ignored_busy", busy, 0);

        for (int v = 0; v < 5; v++) begin
            wq_addr.delete();
            wq_data.delete();
            pulse_start();
            chk({vt[v].name, "_busy_after_start"}, busy, 1);
            send(vt[v].bs, vt[v].len, 0, 1'b0, fa);
            ncyc = cyc - fa + 1;
            chk({vt[v].name, "_done"},     done,     vt[v].exp_done);
            chk({vt[v].name, "_cpu_run"},  cpu_run,  vt[v].exp_done);
            chk({vt[v].name, "_error"},    error,    vt[v].exp_err);
            chk({vt[v].name, "_busy"},     busy,     0);
            chk({vt[v].name, "_in_ready"}, in_ready, 0);
            chk({vt[v].name, "_nwr"},      wq_data.size(), vt[v].exp_nwr);
            chk({vt[v].name, "_cycles"},   ncyc,     vt[v].exp_cyc);
            if (vt[v].exp_nwr >= 1 && wq_data.size() >= 1) begin
                chk({vt[v].name, "_addr0"}, wq_addr[0], 0);
                chk({vt[v].name, "_data0"}, wq_data[0], vt[v].d0);
            end
            if (vt[v].exp_nwr >= 2 && wq_data.size() >= 2) begin
                chk({vt[v].name, "_addr1"}, wq_addr[1], 4);
                chk({vt[v].name, "_data1"}, wq_data[1], vt[v].d1);
            end
        end

        // Error state is left by a fresh start, which clears error.
        pulse_start();
        send(BAD, 11, 0, 1'b0, fa);
        chk("err_then_error", error, 1);
        pulse_start();
        chk("restart_error_clear", error, 0);
        chk("restart_busy",        busy,  1);
        chk("restart_in_ready",    in_ready, 1);
        send(GOOD, 11, 0, 1'b0, fa);
        chk("restart_done", done, 1);

        // Stalled stream with stray start pulses must match the good load.
        wq_addr.delete();
        wq_data.delete();
        pulse_start();
        send(GOOD, 11, 3, 1'b1, fa);
        chk("stall_nwr",     wq_data.size(), 2);
        if (wq_data.size() >= 2) begin
            chk("stall_addr0", wq_addr[0], 0);
            chk("stall_data0", wq_data[0], 32'h20080005);
            chk("stall_addr1", wq_addr[1], 4);
            chk("stall_data1", wq_data[1], 32'h8C090004);
        end
        chk("stall_done",    done,    1);
        chk("stall_cpu_run", cpu_run, 1);
        chk("stall_error",   error,   0);

        // Reset after a partial word: no write, outputs cleared.
        wq_addr.delete();
        wq_data.delete();
        pulse_start();
        send({16'h0001, 16'h2008, 64'h0}, 4, 0, 1'b0, fa);
        chk("partial_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_wr_en",    wr_en,    0);
        chk("midrst_wr_addr",  wr_addr,  0);
        chk("midrst_wr_data",  wr_data,  0);
        chk("midrst_busy",     busy,     0);
        chk("midrst_done",     done,     0);
        chk("midrst_error",    error,    0);
        chk("midrst_cpu_run",  cpu_run,  0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("midrst_nwr", wq_data.size(), 0);
        pulse_start();
        send(ONE, 7, 0, 1'b0, fa);
        chk("after_rst_nwr", wq_data.size(), 1);
        if (wq_data.size() >= 1) begin
            chk("after_rst_addr", wq_addr[0], 0);
            chk("after_rst_data", wq_data[0], 32'h12345678);
        end
        chk("after_rst_done", done, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
